prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time program loader that sits directly upstream of the stack CPU core.
- Takes a byte stream from the UART receiver and assembles it into 16-bit instruction words.
- Writes those words into the word-addressed program/data RAM that the CPU fetches from.
- Holds the CPU in reset until the image has loaded cleanly, then releases it.

Parameters:
- ADDR_W, 15: word-address width of program RAM. The CPU drives address[15]=0, so 15 bits cover the full space.
- BASE_ADDR, 0: first word address written. The CPU starts fetching at ip=0, i.e. word 0.
- TIMEOUT, 1000000: maximum clk cycles allowed between bytes once a load has started. 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- mem_addr  out  16  word address to RAM; bit 15 is always 0.
- mem_wdata  out  16  word to write.
- mem_wr  out  1  one-cycle write strobe.
- cpu_rst_n  out  1  0 holds the CPU in reset; 1 lets it run.
- busy  out  1  high from the first length byte until DONE or ERROR.
- error  out  1  sticky load-failure flag.
- words_loaded  out  16  count of words written so far.

Behaviour:
- Reset values (asynchronous, all outputs): mem_addr=BASE_ADDR, mem_wdata=0, mem_wr=0, cpu_rst_n=0, busy=0, error=0, words_loaded=0, state=LEN_HI.
- Stream format: length high byte, length low byte (N words), then N words, each sent high byte first. The high byte is the opcode the CPU executes first.
- States and transitions:
  - LEN_HI: on rx_valid, latch len[15:8], set busy=1, go to LEN_LO.
  - LEN_LO: on rx_valid, latch len[7:0].
    - N==0: go to DONE (CHECK when the checksum feature is enabled).
    - N > 2^ADDR_W - BASE_ADDR: go to ERROR.
    - Otherwise go to DATA_HI.
  - DATA_HI: on rx_valid, latch hi byte, go to DATA_LO.
  - DATA_LO: on rx_valid, the next cycle drives mem_wr=1 with mem_wdata={hi,rx_data} at the current address.
    - Address and words_loaded increment in the cycle after the write.
    - If words_loaded+1==N, go to DONE (CHECK); else go to DATA_HI.
  - DONE: busy=0, cpu_rst_n=1. Stays here until rst_n; further rx bytes are ignored.
  - ERROR: busy=0, error=1, cpu_rst_n=0. Stays here until rst_n.
- Latency:
  - mem_wr asserts exactly 1 cycle after the rx_valid carrying the low byte.
  - cpu_rst_n rises 1 cycle after the last accepted byte.
- A byte arriving in the cycle that mem_wr is high is accepted normally as the next high byte. There is no write stall; the RAM accepts a write every cycle.
- mem_wr is never high for more than one consecutive cycle per word. mem_addr is stable while mem_wr=1.
- Timeout: a counter runs while busy=1 and clears on each rx_valid. When it reaches TIMEOUT, go to ERROR. The counter is inactive in LEN_HI before the first byte and in DONE/ERROR.
- Address wrap is impossible: the length is checked against capacity before any write.
- Reset mid-load: everything returns to reset values and the CPU is held. Partially written RAM contents are left as-is.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- With the macro: after the last data byte, the FSM enters CHECK and expects one byte equal to the XOR of every preceding byte, including both length bytes.
  - Match: go to DONE.
  - Mismatch: go to ERROR.
  - Timeout also applies in CHECK.
- Without the macro: there is no CHECK state; the last data word goes straight to DONE and no trailer byte is expected.

Test Plan:
- Bytes 00 02 80 05 80 07 (rx_valid 1 cycle, 10 cycles apart):
  - writes {0:8005},{1:8007};
  - words_loaded=2;
  - cpu_rst_n rises 1 cycle after the last byte;
  - busy falls at the same time.
- Back-to-back rx_valid every cycle with N=3: three single-cycle mem_wr pulses at addresses 0,1,2 with correct data, and no byte dropped.
- Length 00 00: no mem_wr, immediate DONE, cpu_rst_n=1; with CHECKSUM_EN, trailer 00 is required first.
- Length 80 01 with ADDR_W=15: ERROR, error=1, no mem_wr, cpu_rst_n stays 0.
- TIMEOUT=20; send 00 01 80 then silence: ERROR exactly 20 cycles after the byte 80; no write issued.
- CHECKSUM_EN; stream 00 01 12 34 trailer 27 → DONE; trailer 26 → ERROR, with the RAM word written but cpu_rst_n=0.
- rst_n pulsed low mid-stream: outputs reset asynchronously; the next full stream loads correctly from BASE_ADDR.

Source files
------------

// File: rtl/prog_loader.sv
// Boot loader: assembles a length-prefixed UART byte stream into 16-bit words, writes them to
// program RAM and releases the CPU from reset. Define PROG_LOADER_CHECKSUM_EN for an XOR trailer check.
module prog_loader #(
    parameter int ADDR_W    = 15,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_wr,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        error,
    output logic [15:0] words_loaded,
    output logic [2:0]  dbg_state
);

    // rx_valid is a one-cycle strobe with no back-pressure: every strobe is consumed by
    // the state it arrives in. mem_wr is a one-cycle strobe the RAM always accepts.
    localparam logic [2:0] S_LEN_HI  = 3'd0;
    localparam logic [2:0] S_LEN_LO  = 3'd1;
    localparam logic [2:0] S_DATA_HI = 3'd2;
    localparam logic [2:0] S_DATA_LO = 3'd3;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK   = 3'd4;
    localparam logic [2:0] S_FINAL   = S_CHECK;
`else
    localparam logic [2:0] S_FINAL   = 3'd5;
`endif
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERROR   = 3'd6;

    localparam logic [16:0] CAPACITY = 17'((32'd1 << ADDR_W) - BASE_ADDR);

    localparam bit             TO_EN   = (TIMEOUT > 0);
    localparam int             TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [7:0]        r_len_hi;
    logic [15:0]       r_len;
    logic [7:0]        r_hi;
    logic              r_mem_wr;
    logic [15:0]       r_mem_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_words;
    logic              r_busy;
    logic              r_cpu_rst_n;
    logic              r_error;
    logic [TO_W-1:0]   r_to_cnt;

    logic [15:0]       w_len;
    logic              w_len_too_big;
    logic              w_last_word;
    logic              w_timeout;

    assign w_len         = {r_len_hi, rx_data};
    assign w_len_too_big = {1'b0, w_len} > CAPACITY;
    assign w_last_word   = (r_words + 16'd1) == r_len;
    assign w_timeout     = TO_EN && r_busy && !rx_valid && (r_to_cnt == TO_LAST);

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    // Running XOR of every byte before the trailer, length bytes included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= 8'h00;
        end else if (rx_valid && (r_state == S_LEN_HI || r_state == S_LEN_LO ||
                                  r_state == S_DATA_HI || r_state == S_DATA_LO)) begin
            r_csum <= r_csum ^ rx_data;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LEN_HI: if (rx_valid) w_state_nxt = S_LEN_LO;
            S_LEN_LO: begin
                if (rx_valid) begin
                    if (w_len == 16'd0)
                        w_state_nxt = S_FINAL;
                    else if (w_len_too_big)
                        w_state_nxt = S_ERROR;
                    else
                        w_state_nxt = S_DATA_HI;
                end
            end
            S_DATA_HI: if (rx_valid) w_state_nxt = S_DATA_LO;
            S_DATA_LO: if (rx_valid) w_state_nxt = w_last_word ? S_FINAL : S_DATA_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHECK: if (rx_valid) w_state_nxt = (rx_data == r_csum) ? S_DONE : S_ERROR;
`endif
            S_DONE, S_ERROR: w_state_nxt = r_state;
            default: w_state_nxt = S_ERROR;
        endcase
        if (w_timeout)
            w_state_nxt = S_ERROR;
    end

    // Status flags are registered from the next state so cpu_rst_n never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_LEN_HI;
            r_busy      <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt != S_LEN_HI) && (w_state_nxt != S_DONE) &&
                           (w_state_nxt != S_ERROR);
            r_cpu_rst_n <= (w_state_nxt == S_DONE);
            r_error     <= (w_state_nxt == S_ERROR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len_hi    <= 8'h00;
            r_len       <= 16'h0000;
            r_hi        <= 8'h00;
            r_mem_wr    <= 1'b0;
            r_mem_wdata <= 16'h0000;
            r_addr      <= ADDR_W'(BASE_ADDR);
            r_words     <= 16'h0000;
        end else begin
            r_mem_wr <= 1'b0;
            // Address advances only after the write cycle so it is stable under mem_wr.
            if (r_mem_wr) begin
                r_addr  <= r_addr + ADDR_W'(1);
                r_words <= r_words + 16'd1;
            end
            if (rx_valid && r_state == S_LEN_HI)
                r_len_hi <= rx_data;
            if (rx_valid && r_state == S_LEN_LO)
                r_len <= w_len;
            if (rx_valid && r_state == S_DATA_HI)
                r_hi <= rx_data;
            if (rx_valid && r_state == S_DATA_LO) begin
                r_mem_wr    <= 1'b1;
                r_mem_wdata <= {r_hi, rx_data};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_to_cnt <= '0;
        else if (!r_busy || rx_valid)
            r_to_cnt <= '0;
        else if (!w_timeout)
            r_to_cnt <= r_to_cnt + TO_W'(1);
    end

    assign mem_addr     = {1'b0, 15'(r_addr)};
    assign mem_wdata    = r_mem_wdata;
    assign mem_wr       = r_mem_wr;
    assign cpu_rst_n    = r_cpu_rst_n;
    assign busy         = r_busy;
    assign error        = r_error;
    assign words_loaded = r_words;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: byte-stream driver, write scoreboard, final report.
// Build with PROG_LOADER_CHECKSUM_EN to exercise the trailer-byte variant.
module tb_prog_loader;

    localparam int TB_TIMEOUT = 20;
    localparam logic [2:0] S_LEN_HI  = 3'd0;
    localparam logic [2:0] S_DATA_HI = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERROR   = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_wr;
    logic        cpu_rst_n;
    logic        busy;
    logic        error;
    logic [15:0] words_loaded;
    logic [2:0]  dbg_state;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  tb_xor;
    logic [15:0] exp_addr;
    logic        prev_wr = 1'b0;

    prog_loader #(.ADDR_W(15), .BASE_ADDR(0), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wr       (mem_wr),
        .cpu_rst_n    (cpu_rst_n),
        .busy         (busy),
        .error        (error),
        .words_loaded (words_loaded),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic b, input logic c, input logic e);
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
        check({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, c});
        check({tag, "_error"}, {31'd0, error}, {31'd0, e});
    endtask

    // Write monitor: every mem_wr pulse must match the oldest expected {addr, data}.
    always @(negedge clk) begin
        if (mem_wr) begin
            check("wr_single_cycle", {31'd0, prev_wr}, 32'd0);
            check("mem_write", {mem_addr, mem_wdata},
                  (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF);
        end
        prev_wr = mem_wr;
    end

    // All driver tasks start and end on a falling edge.
    task automatic send_byte(input logic [7:0] b, input int idle);
        rx_data  = b;
        rx_valid = 1'b1;
        tb_xor   = tb_xor ^ b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (idle) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w, input int idle);
        send_byte(w[15:8], idle);
        exp_q.push_back({exp_addr, w});
        exp_addr = exp_addr + 16'd1;
        send_byte(w[7:0], idle);
    endtask

    task automatic send_trailer(input bit good, input int idle);
`ifdef PROG_LOADER_CHECKSUM_EN
        logic [7:0] t;
        t = good ? tb_xor : (tb_xor ^ 8'h01);
        send_byte(t, idle);
`else
        repeat (idle + (good ? 1 : 1)) @(negedge clk);
`endif
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tb_xor   = 8'h00;
        exp_addr = 16'h0000;
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] last;
        int         n;
        int         cyc;

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tb_xor   = 8'h00;
        exp_addr = 16'h0000;
        #3;
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_words", {16'd0, words_loaded}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, {29'd0, S_LEN_HI});
        check_flags("rst", 1'b0, 1'b0, 1'b0);

        // Stream 00 02 80 05 80 07, bytes 10 cycles apart.
        do_reset();
        send_byte(8'h00, 9);
        check("t1_busy_first_byte", {31'd0, busy}, 32'd1);
        send_byte(8'h02, 9);
        send_byte(8'h80, 9);
        exp_q.push_back({16'h0000, 16'h8005});
        send_byte(8'h05, 0);
        check("t1_wr_latency", {31'd0, mem_wr}, 32'd1);
        repeat (9) @(negedge clk);
        send_byte(8'h80, 9);
        exp_q.push_back({16'h0001, 16'h8007});
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h07, 9);
        last = 8'h00;
`else
        last = 8'h07;
`endif
        check_flags("t1_pre_last", 1'b1, 1'b0, 1'b0);
        send_byte(last, 0);
        check_flags("t1_post_last", 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("t1_words", {16'd0, words_loaded}, 32'd2);
        check("t1_addr", {16'd0, mem_addr}, 32'd2);
        check("t1_state", {29'd0, dbg_state}, {29'd0, S_DONE});
        check("t1_pending", exp_q.size(), 32'd0);
        send_byte(8'hAA, 1);
        send_byte(8'hBB, 1);
        check("t1_ignore_words", {16'd0, words_loaded}, 32'd2);
        check("t1_ignore_state", {29'd0, dbg_state}, {29'd0, S_DONE});

        // Back-to-back bytes, N=3.
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_word(16'hA1B2, 0);
        send_word(16'hC3D4, 0);
        send_word(16'hE5F6, 0);
        send_trailer(1'b1, 0);
        repeat (3) @(negedge clk);
        check("t2_words", {16'd0, words_loaded}, 32'd3);
        check("t2_pending", exp_q.size(), 32'd0);
        check_flags("t2_done", 1'b0, 1'b1, 1'b0);

        // Random words with random gaps.
        do_reset();
        n = $urandom_range(4, 8);
        send_byte(8'h00, $urandom_range(0, 3));
        send_byte(8'(n), $urandom_range(0, 3));
        for (int i = 0; i < n; i++)
            send_word(16'($urandom_range(0, 65535)), $urandom_range(0, 3));
        send_trailer(1'b1, 0);
        repeat (3) @(negedge clk);
        check("t3_words", {16'd0, words_loaded}, n);
        check("t3_pending", exp_q.size(), 32'd0);
        check_flags("t3_done", 1'b0, 1'b1, 1'b0);

        // Zero-length image.
        do_reset();
        send_byte(8'h00, 1);
        send_byte(8'h00, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        check_flags("t4_wait_trailer", 1'b1, 1'b0, 1'b0);
        send_byte(8'h00, 0);
`endif
        check_flags("t4_done", 1'b0, 1'b1, 1'b0);
        check("t4_state", {29'd0, dbg_state}, {29'd0, S_DONE});
        check("t4_words", {16'd0, words_loaded}, 32'd0);

        // Length one past capacity.
        do_reset();
        send_byte(8'h80, 1);
        send_byte(8'h01, 0);
        check_flags("t5_err", 1'b0, 1'b0, 1'b1);
        check("t5_state", {29'd0, dbg_state}, {29'd0, S_ERROR});
        send_byte(8'h12, 0);
        send_byte(8'h34, 3);
        check("t5_words", {16'd0, words_loaded}, 32'd0);
        check("t5_cpu_held", {31'd0, cpu_rst_n}, 32'd0);

        // Length exactly at capacity is accepted; then idle into a timeout.
        do_reset();
        send_byte(8'h80, 0);
        send_byte(8'h00, 0);
        check("t6_state", {29'd0, dbg_state}, {29'd0, S_DATA_HI});
        check_flags("t6_accept", 1'b1, 1'b0, 1'b0);
        repeat (TB_TIMEOUT + 5) @(negedge clk);
        check_flags("t6_timeout", 1'b0, 1'b0, 1'b1);

        // Timeout latency: ERROR exactly TB_TIMEOUT cycles after the last byte.
        do_reset();
        send_byte(8'h00, 2);
        send_byte(8'h01, 2);
        send_byte(8'h80, 0);
        cyc = 0;
        while (!error && cyc <= 2 * TB_TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        check("t7_timeout_cycles", cyc, TB_TIMEOUT);
        check("t7_words", {16'd0, words_loaded}, 32'd0);
        check_flags("t7_err", 1'b0, 1'b0, 1'b1);

        // Stream 00 01 12 34 with good and bad trailers.
        do_reset();
        send_byte(8'h00, 1);
        send_byte(8'h01, 1);
        send_word(16'h1234, 1);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h27, 2);
`endif
        check_flags("t8_good", 1'b0, 1'b1, 1'b0);
        check("t8_pending", exp_q.size(), 32'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
        do_reset();
        send_byte(8'h00, 1);
        send_byte(8'h01, 1);
        send_word(16'h1234, 1);
        send_byte(8'h26, 2);
        check_flags("t8_bad", 1'b0, 1'b0, 1'b1);
        check("t8_bad_words", {16'd0, words_loaded}, 32'd1);
        check("t8_bad_pending", exp_q.size(), 32'd0);
`endif

        // Asynchronous reset mid-stream, then a clean reload from address 0.
        do_reset();
        send_byte(8'h00, 1);
        send_byte(8'h03, 1);
        send_word(16'hAABB, 1);
        send_byte(8'hCC, 2);
        check("t9_pending", exp_q.size(), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t9_async_words", {16'd0, words_loaded}, 32'd0);
        check("t9_async_addr", {16'd0, mem_addr}, 32'd0);
        check("t9_async_state", {29'd0, dbg_state}, {29'd0, S_LEN_HI});
        check_flags("t9_async", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(16'h0102, 0);
        send_word(16'hFEDC, 0);
        send_trailer(1'b1, 0);
        repeat (3) @(negedge clk);
        check("t9_reload_words", {16'd0, words_loaded}, 32'd2);
        check_flags("t9_reload", 1'b0, 1'b1, 1'b0);

        check("final_pending", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
